// File: rtl/cost_server_pkg.sv
// rtl/cost_server_pkg.sv - shared types and dimensions for cost_server
//
// Optional feature macro: COST_SERVER_CHECKSUM_EN (adds the checksum width).
// Contents:
//   state_t     - LOAD / SERVE / CAPTURE / HALT
//   TBL_DIM     - table rows and columns (workers x jobs)
//   TBL_DEPTH   - number of table entries
//   IDX_W       - load index width
//   SEL_W       - worker/job selector width
//   CYC_W       - SERVE cycle counter width
//   RES_CNT_W   - captured MatchCount width
//   RES_COST_W  - captured MinCost width
//   tbl_index() - flattens {worker, job} into a row-major load index
package cost_server_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam int TBL_DIM    = 8;
  localparam int TBL_DEPTH  = TBL_DIM * TBL_DIM;
  localparam int IDX_W      = 6;
  localparam int SEL_W      = 3;
  localparam int CYC_W      = 16;
  localparam int RES_CNT_W  = 4;
  localparam int RES_COST_W = 10;
`ifdef COST_SERVER_CHECKSUM_EN
  localparam int CSUM_W     = 13;
`endif

  // Worker is the major index, job the minor one.
  function automatic logic [IDX_W-1:0] tbl_index(input logic [SEL_W-1:0] w,
                                                 input logic [SEL_W-1:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/cost_table.sv
// rtl/cost_table.sv - 8x8 cost storage, one sync write port, one comb read port
//
// Ports:
//   i_clk     in   write clock (rising edge)
//   i_rst_n   in   asynchronous active-low clear of every entry
//   i_we      in   write enable
//   i_waddr   in   row-major write index
//   i_wdata   in   write data
//   i_rd_w    in   read worker index
//   i_rd_j    in   read job index
//   o_rdata   out  entry [i_rd_w][i_rd_j], combinational
module cost_table
  import cost_server_pkg::*;
#(
  parameter int COST_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [COST_W-1:0] i_wdata,
  input  logic [SEL_W-1:0]  i_rd_w,
  input  logic [SEL_W-1:0]  i_rd_j,
  output logic [COST_W-1:0] o_rdata
);

  logic [COST_W-1:0] r_mem [TBL_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[tbl_index(i_rd_w, i_rd_j)];

endmodule

// File: rtl/cost_server.sv
// rtl/cost_server.sv - cost table loader/server with solver result capture
//
// Optional feature macro: COST_SERVER_CHECKSUM_EN (adds CHECKSUM output).
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   LD_VALID    in   load word valid
//   LD_DATA     in   load word, row-major (worker-major, job-minor)
//   LD_READY    out  load word accepted this cycle when LD_VALID
//   W, J        in   solver worker/job lookup indices
//   Cost        out  table[W][J], combinational, 0 while loading
//   Valid       in   solver result strobe
//   MatchCount  in   solver result count
//   MinCost     in   solver result minimum
//   Ready       out  table loaded, solver may run
//   Done        out  result captured (held until reset)
//   Timeout     out  solver gave no result in time (held until reset)
//   RES_COUNT   out  captured MatchCount
//   RES_COST    out  captured MinCost
//   CYC_COUNT   out  SERVE cycles elapsed, saturating
//   CHECKSUM    out  running sum of accepted load words (macro only)
module cost_server
  import cost_server_pkg::*;
#(
  parameter int COST_W      = 7,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD_VALID,
  input  logic [COST_W-1:0]     LD_DATA,
  output logic                  LD_READY,
  input  logic [SEL_W-1:0]      W,
  input  logic [SEL_W-1:0]      J,
  output logic [COST_W-1:0]     Cost,
  input  logic                  Valid,
  input  logic [RES_CNT_W-1:0]  MatchCount,
  input  logic [RES_COST_W-1:0] MinCost,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Timeout,
  output logic [RES_CNT_W-1:0]  RES_COUNT,
  output logic [RES_COST_W-1:0] RES_COST,
`ifdef COST_SERVER_CHECKSUM_EN
  output logic [CSUM_W-1:0]     CHECKSUM,
`endif
  output logic [CYC_W-1:0]      CYC_COUNT
);

  // Counter value seen on the last permitted SERVE cycle.
  localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TBL_DEPTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CYC_W-1:0]      r_cyc_count;
  logic                  r_done;
  logic                  r_timeout;
  logic [RES_CNT_W-1:0]  r_res_count;
  logic [RES_COST_W-1:0] r_res_cost;
  logic                  w_ld_accept;
  logic                  w_capture;
  logic                  w_timeout_hit;
  logic [COST_W-1:0]     w_rdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    LD_READY      = 1'b0;
    Ready         = 1'b1;
    w_ld_accept   = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_LOAD: begin
        LD_READY    = 1'b1;
        Ready       = 1'b0;
        w_ld_accept = LD_VALID;
        if (LD_VALID && (r_idx == IDX_LAST)) begin
          w_next_state = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // A result arriving on the final allowed cycle still counts.
        if (Valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_CAPTURE;
        end else if (r_cyc_count == TO_LAST) begin
          w_timeout_hit = 1'b1;
          w_next_state  = ST_HALT;
        end
      end
      ST_CAPTURE: begin
        w_next_state = ST_HALT;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx       <= '0;
      r_cyc_count <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_res_count <= '0;
      r_res_cost  <= '0;
    end else begin
      if (w_ld_accept) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if ((r_state == ST_SERVE) && (r_cyc_count != '1)) begin
        r_cyc_count <= r_cyc_count + CYC_W'(1);
      end
      if (w_capture) begin
        r_done      <= 1'b1;
        r_res_count <= MatchCount;
        r_res_cost  <= MinCost;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef COST_SERVER_CHECKSUM_EN
  logic [CSUM_W-1:0] r_checksum;

  // Only accepted words are summed, so the value freezes once LOAD ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_checksum <= '0;
    end else if (w_ld_accept) begin
      r_checksum <= r_checksum + CSUM_W'(LD_DATA);
    end
  end

  assign CHECKSUM = r_checksum;
`endif

  cost_table #(
    .COST_W (COST_W)
  ) u_table (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_we    (w_ld_accept),
    .i_waddr (r_idx),
    .i_wdata (LD_DATA),
    .i_rd_w  (W),
    .i_rd_j  (J),
    .o_rdata (w_rdata)
  );

  // The solver must not see partially loaded data.
  assign Cost      = (r_state == ST_LOAD) ? '0 : w_rdata;
  assign Done      = r_done;
  assign Timeout   = r_timeout;
  assign RES_COUNT = r_res_count;
  assign RES_COST  = r_res_cost;
  assign CYC_COUNT = r_cyc_count;

endmodule

// File: tb/tb_cost_server.sv
// tb/tb_cost_server.sv - randomized bench for cost_server against a behavioural model
module tb_cost_server;

  localparam int COST_W = 7;
  localparam int TO     = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [6:0]  ld_data = '0;
  logic        ld_ready;
  logic [2:0]  w = '0;
  logic [2:0]  j = '0;
  logic [6:0]  cost;
  logic        valid = 1'b0;
  logic [3:0]  match_count = '0;
  logic [9:0]  min_cost = '0;
  logic        ready;
  logic        done;
  logic        timeout;
  logic [3:0]  res_count;
  logic [9:0]  res_cost;
  logic [15:0] cyc_count;
`ifdef COST_SERVER_CHECKSUM_EN
  logic [12:0] checksum;
`endif

  always #5 clk = ~clk;

  cost_server #(
    .COST_W      (COST_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .LD_VALID   (ld_valid),
    .LD_DATA    (ld_data),
    .LD_READY   (ld_ready),
    .W          (w),
    .J          (j),
    .Cost       (cost),
    .Valid      (valid),
    .MatchCount (match_count),
    .MinCost    (min_cost),
    .Ready      (ready),
    .Done       (done),
    .Timeout    (timeout),
    .RES_COUNT  (res_count),
    .RES_COST   (res_cost),
`ifdef COST_SERVER_CHECKSUM_EN
    .CHECKSUM   (checksum),
`endif
    .CYC_COUNT  (cyc_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: words loaded so far, SERVE cycles spent, result flags.
  int m_tbl [64];
  int m_loaded = 0;
  int m_serve  = 0;
  bit m_done   = 0;
  bit m_to     = 0;
  int m_rcnt   = 0;
  int m_rcost  = 0;
  int m_sum    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_tbl[k]) m_tbl[k] = 0;
      m_loaded = 0;
      m_serve  = 0;
      m_done   = 0;
      m_to     = 0;
      m_rcnt   = 0;
      m_rcost  = 0;
      m_sum    = 0;
    end else if (m_loaded < 64) begin
      if (ld_valid) begin
        m_tbl[m_loaded] = int'(ld_data);
        m_sum += int'(ld_data);
        m_loaded++;
      end
    end else if (!m_done && !m_to) begin
      if (valid) begin
        m_done  = 1;
        m_rcnt  = int'(match_count);
        m_rcost = int'(min_cost);
      end else if (m_serve == TO - 1) begin
        m_to = 1;
      end
      m_serve++;
    end
  end

  // Every-cycle comparison, sampled away from the active edge.
  always @(negedge clk) begin
    check("ld_ready", int'(ld_ready), (m_loaded < 64) ? 1 : 0);
    check("ready", int'(ready), (m_loaded == 64) ? 1 : 0);
    check("cost", int'(cost), (m_loaded < 64) ? 0 : m_tbl[int'(w) * 8 + int'(j)]);
    check("done", int'(done), int'(m_done));
    check("timeout", int'(timeout), int'(m_to));
    check("res_count", int'(res_count), m_rcnt);
    check("res_cost", int'(res_cost), m_rcost);
    check("cyc_count", int'(cyc_count), (m_serve > 65535) ? 65535 : m_serve);
`ifdef COST_SERVER_CHECKSUM_EN
    check("checksum", int'(checksum), m_sum % 8192);
`endif
  end

  bit pin_wj = 0;

  task automatic step();
    if (!pin_wj) begin
      w = 3'($urandom_range(0, 7));
      j = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ld_valid = 0;
    valid    = 0;
    rst_n    = 0;
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_cost", int'(cost), 0);
    check("rst_done", int'(done), 0);
    step();
    step();
    rst_n = 1;
    step();
    check("post_rst_ld_ready", int'(ld_ready), 1);
  endtask

  // mode 0: idx*2 mod 128, 1: random, 2: all 127
  task automatic load_words(int mode);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1;
      case (mode)
        0:       ld_data = 7'((i * 2) % 128);
        1:       ld_data = 7'($urandom);
        default: ld_data = 7'd127;
      endcase
      valid       = 1'($urandom);
      match_count = 4'($urandom);
      min_cost    = 10'($urandom);
      if (i == 63) check("ready_before_last", int'(ready), 0);
      step();
    end
    ld_valid = 0;
    valid    = 0;
    check("ready_after_last", int'(ready), 1);
  endtask

  task automatic sweep_table();
    pin_wj = 1;
    for (int i = 0; i < 64; i++) begin
      w = 3'(i / 8);
      j = 3'(i % 8);
      step();
    end
    pin_wj = 0;
  endtask

  initial begin
    step();
    do_reset();

    // Deterministic load, lookup, and result capture.
    load_words(0);
    pin_wj = 1;
    w = 3'd3;
    j = 3'd5;
    #1;
    check("cost_3_5", int'(cost), 58);
    pin_wj = 0;
    for (int i = 0; i < 3; i++) step();
    valid       = 1;
    match_count = 4'd12;
    min_cost    = 10'd331;
    step();
    valid = 0;
    check("done_next", int'(done), 1);
    check("res_count_12", int'(res_count), 12);
    check("res_cost_331", int'(res_cost), 331);
    for (int i = 0; i < 100; i++) begin
      valid       = 1'($urandom);
      match_count = 4'($urandom);
      min_cost    = 10'($urandom);
      ld_valid    = 1'($urandom);
      ld_data     = 7'($urandom);
      step();
    end
    valid    = 0;
    ld_valid = 0;
    check("held_done", int'(done), 1);
    check("held_count", int'(res_count), 12);
    check("held_cost", int'(res_cost), 331);

    // Toggling load valid, then timeout with no result.
    do_reset();
    for (int c = 0; c < 128; c++) begin
      ld_valid = (c % 2 == 0);
      ld_data  = 7'($urandom);
      step();
    end
    ld_valid = 0;
    check("ld_ready_after_toggle", int'(ld_ready), 0);
    sweep_table();
    check("timeout_set", int'(timeout), 1);
    check("timeout_no_done", int'(done), 0);
    check("timeout_cyc", int'(cyc_count), 20);
    valid = 1;
    step();
    valid = 0;
    step();
    check("late_valid_ignored", int'(done), 0);

    // Result arriving on the last permitted SERVE cycle.
    do_reset();
    load_words(1);
    for (int k = 1; k < TO; k++) step();
    valid       = 1;
    match_count = 4'($urandom);
    min_cost    = 10'($urandom);
    step();
    valid = 0;
    check("edge_done", int'(done), 1);
    check("edge_no_timeout", int'(timeout), 0);
    check("edge_cyc", int'(cyc_count), 20);
    for (int i = 0; i < 5; i++) step();

    // Reset in the middle of a load, then reload.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      ld_valid = 1;
      ld_data  = 7'($urandom);
      step();
    end
    ld_valid = 0;
    rst_n    = 0;
    #1;
    check("midload_ready", int'(ready), 0);
    check("midload_cost", int'(cost), 0);
    step();
    step();
    rst_n = 1;
    step();
    load_words(2);
    pin_wj = 1;
    w = 3'($urandom_range(0, 7));
    j = 3'($urandom_range(0, 7));
    #1;
    check("reload_cost", int'(cost), 127);
    pin_wj = 0;
`ifdef COST_SERVER_CHECKSUM_EN
    check("checksum_8128", int'(checksum), 8128);
`endif
    sweep_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
